// File: rtl/exc_flush_ctrl.sv
// Exception/ERTN flush sequencer beside WB: cancel, CSR commit strobes, stale I-fetch drain, redirect.
// Optional performance counters are enabled by defining EXC_PERF_CNT_EN.
module exc_flush_ctrl #(
  parameter int OUTST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [5:0]  wb_exc,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_fault_vaddr,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        inst_ar_fire,
  input  logic        inst_r_fire,
  output logic        outst_full,
  output logic        inst_r_discard,
  output logic        cancel_exc_ertn,
  output logic        exc_commit,
  output logic [5:0]  exc_ecode,
  output logic [8:0]  exc_esubcode,
  output logic        exc_badv_we,
  output logic [31:0] exc_badv,
  output logic [31:0] exc_era,
  output logic        ertn_commit,
  output logic        fetch_hold,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] exc_cnt,
  output logic [31:0] flush_cyc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] OUTST_MAX_C = CNT_W'(OUTST_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  logic        exc_any_s;
  logic        trigger_s;
  logic [5:0]  ecode_s;
  logic        badv_we_s;
  logic [31:0] badv_s;

  assign exc_any_s = |wb_exc;
  assign trigger_s = resetn & (state_q == ST_IDLE) & wb_valid & (exc_any_s | ertn_flush);

  // Exception priority encoder: INT > ADEF > INE > SYS > BRK > ALE
  always_comb begin
    ecode_s   = 6'h00;
    badv_we_s = 1'b0;
    badv_s    = 32'h0;
    if (wb_exc[0]) begin
      ecode_s = 6'h00;
    end else if (wb_exc[5]) begin
      ecode_s   = 6'h08;
      badv_we_s = 1'b1;
      badv_s    = wb_pc;
    end else if (wb_exc[1]) begin
      ecode_s = 6'h0D;
    end else if (wb_exc[3]) begin
      ecode_s = 6'h0B;
    end else if (wb_exc[2]) begin
      ecode_s = 6'h0C;
    end else if (wb_exc[4]) begin
      ecode_s   = 6'h09;
      badv_we_s = 1'b1;
      badv_s    = wb_fault_vaddr;
    end else begin
      ecode_s = 6'h00;
    end
  end

  // Outstanding instruction-read tracker
  always_comb begin
    outst_d = outst_q;
    case ({inst_ar_fire, inst_r_fire})
      2'b10:   outst_d = (outst_q < OUTST_MAX_C) ? outst_q + CNT_ONE : outst_q;
      2'b01:   outst_d = (outst_q != CNT_ZERO) ? outst_q - CNT_ONE : outst_q;
      default: outst_d = outst_q;
    endcase
  end

  // Flush FSM next state and handshake outputs
  always_comb begin
    state_d         = state_q;
    discard_d       = discard_q;
    redirect_pc_d   = redirect_pc_q;
    cancel_exc_ertn = 1'b0;
    fetch_hold      = 1'b0;
    inst_r_discard  = 1'b0;
    redirect_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          cancel_exc_ertn = 1'b1;
          redirect_pc_d   = exc_any_s ? csr_eentry : csr_era;
          // An AR accepted this cycle is already stale; an R beat this cycle is consumed.
          discard_d       = outst_d;
          state_d         = (outst_d != CNT_ZERO) ? ST_DRAIN : ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        cancel_exc_ertn = 1'b1;
        fetch_hold      = 1'b1;
        inst_r_discard  = 1'b1;
        if (inst_r_fire) begin
          discard_d = (discard_q != CNT_ZERO) ? discard_q - CNT_ONE : CNT_ZERO;
          state_d   = (discard_q <= CNT_ONE) ? ST_REDIRECT : ST_DRAIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REDIRECT: begin
        cancel_exc_ertn = 1'b1;
        fetch_hold      = 1'b1;
        redirect_valid  = 1'b1;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and tracker registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      outst_q       <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign outst_full   = (outst_q == OUTST_MAX_C);
  assign redirect_pc  = redirect_pc_q;
  assign exc_commit   = trigger_s & exc_any_s;
  assign ertn_commit  = trigger_s & ~exc_any_s;
  assign exc_ecode    = exc_commit ? ecode_s : 6'h00;
  assign exc_esubcode = 9'h000;
  assign exc_badv_we  = exc_commit & badv_we_s;
  assign exc_badv     = exc_commit ? badv_s : 32'h0;
  assign exc_era      = exc_commit ? wb_pc : 32'h0;

`ifdef EXC_PERF_CNT_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;
  logic [31:0] flush_cyc_cnt_q, flush_cyc_cnt_d;

  // Performance counter next values
  always_comb begin
    exc_cnt_d       = exc_commit ? exc_cnt_q + 32'd1 : exc_cnt_q;
    flush_cyc_cnt_d = (state_q != ST_IDLE) ? flush_cyc_cnt_q + 32'd1 : flush_cyc_cnt_q;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_cnt_q       <= 32'h0;
      flush_cyc_cnt_q <= 32'h0;
    end else begin
      exc_cnt_q       <= exc_cnt_d;
      flush_cyc_cnt_q <= flush_cyc_cnt_d;
    end
  end

  assign exc_cnt       = exc_cnt_q;
  assign flush_cyc_cnt = flush_cyc_cnt_q;
`else
  assign exc_cnt       = 32'h0;
  assign flush_cyc_cnt = 32'h0;
`endif

endmodule
